// File: rtl/rv_iommu_field_pkg.sv
// Shared types and helpers for IOMMU register fields: the SW access
// permission code and predicates derived from it.
package rv_iommu_field_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

    // Anything not listed is treated as read-only by the field logic.
    function automatic logic sw_writable(sw_access_e acc);
        case (acc)
            SwAccessRW, SwAccessWO, SwAccessW1C,
            SwAccessW1S, SwAccessW0C: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic sw_readable(sw_access_e acc);
        return (acc != SwAccessWO);
    endfunction

    function automatic logic sw_legal(sw_access_e acc);
        case (acc)
            SwAccessRW, SwAccessRO, SwAccessWO, SwAccessW1C,
            SwAccessW1S, SwAccessW0C, SwAccessRC: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_iommu_reg_field_arb.sv
// Combinational next-value and update-enable selection for one register
// field, merging a pre-qualified SW write with the HW update path.
module rv_iommu_reg_field_arb
    import rv_iommu_field_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter sw_access_e SWACCESS   = SwAccessRW
) (
    input  logic [DATA_WIDTH-1:0] q,
    input  logic                  sw_we,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  re,
    input  logic                  de,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] ds,
    output logic                  wr_en
);

    localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE  = {DATA_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] base;

    // Next value per access type; unknown codes fall back to read-only.
    always_comb begin
        base  = de ? d : q;
        ds    = base;
        wr_en = de;
        case (SWACCESS)
            SwAccessRW, SwAccessWO: begin
                if (sw_we) begin
                    ds = wd;
                end else begin
                    ds = base;
                end
                wr_en = sw_we | de;
            end
            SwAccessW1C: begin
                ds    = base & (sw_we ? ~wd : ALL_ONE);
                wr_en = sw_we | de;
            end
            SwAccessW1S: begin
                ds    = base | (sw_we ? wd : ALL_ZERO);
                wr_en = sw_we | de;
            end
            SwAccessW0C: begin
                ds    = base & (sw_we ? wd : ALL_ONE);
                wr_en = sw_we | de;
            end
            SwAccessRC: begin
                // Read-clear beats a coincident HW set; that HW value is dropped.
                ds    = re ? ALL_ZERO : base;
                wr_en = re | de;
            end
            default: begin
                ds    = base;
                wr_en = de;
            end
        endcase
    end

endmodule

// File: rtl/rv_iommu_reg_field.sv
// One SW/HW-shared IOMMU register field: storage flops, write-lock gating,
// write strobe and write-error pulse, and SW read-back.
module rv_iommu_reg_field
    import rv_iommu_field_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter sw_access_e            SWACCESS   = SwAccessRW,
    parameter logic [DATA_WIDTH-1:0] RESVAL     = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  re_i,
    input  logic                  lock_i,
    input  logic                  de_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic                  qe_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic [DATA_WIDTH-1:0] ds_o,
    output logic [DATA_WIDTH-1:0] qs_o,
    output logic                  err_o
);

    localparam logic WRITABLE = sw_writable(SWACCESS);
    localparam logic READABLE = sw_readable(SWACCESS);

    if (!sw_legal(SWACCESS)) begin : g_bad_access
        $error("rv_iommu_reg_field: illegal SWACCESS code");
    end

    logic [DATA_WIDTH-1:0] q_r;
    logic                  qe_r;
    logic                  err_r;
    logic                  sw_we;
    logic                  sw_err;
    logic [DATA_WIDTH-1:0] ds;
    logic                  wr_en;

    assign sw_we  = we_i & ~lock_i & WRITABLE;
    assign sw_err = we_i & (lock_i | ~WRITABLE);

    rv_iommu_reg_field_arb #(
        .DATA_WIDTH (DATA_WIDTH),
        .SWACCESS   (SWACCESS)
    ) u_arb (
        .q     (q_r),
        .sw_we (sw_we),
        .wd    (wd_i),
        .re    (re_i),
        .de    (de_i),
        .d     (d_i),
        .ds    (ds),
        .wr_en (wr_en)
    );

    // Field storage plus the strobe/error pulses aligned with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_r   <= RESVAL;
            qe_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (wr_en) begin
                q_r <= ds;
            end
            qe_r  <= sw_we;
            err_r <= sw_err;
        end
    end

    assign q_o   = q_r;
    assign qe_o  = qe_r;
    assign err_o = err_r;
    assign ds_o  = ds;
    assign qs_o  = READABLE ? q_r : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_rv_iommu_reg_field.sv
// Directed, table-driven bench: one 8-bit field instance per access type,
// each with its own input bus so only the targeted instance is stimulated.
module tb_rv_iommu_reg_field;
    import rv_iommu_field_pkg::*;

    localparam int ND = 7;
    localparam int NV = 28;

    function automatic sw_access_e acc_of(int i);
        case (i)
            0:       return SwAccessRW;
            1:       return SwAccessW1C;
            2:       return SwAccessW1S;
            3:       return SwAccessRO;
            4:       return SwAccessRC;
            5:       return SwAccessWO;
            default: return SwAccessW0C;
        endcase
    endfunction

    logic       clk;
    logic       rst_n;
    logic       we   [ND];
    logic [7:0] wd   [ND];
    logic       re   [ND];
    logic       lock [ND];
    logic       de   [ND];
    logic [7:0] d    [ND];
    logic       qe   [ND];
    logic [7:0] q    [ND];
    logic [7:0] ds   [ND];
    logic [7:0] qs   [ND];
    logic       err  [ND];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        rv_iommu_reg_field #(
            .DATA_WIDTH (8),
            .SWACCESS   (acc_of(g)),
            .RESVAL     (8'h5A)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .we_i   (we[g]),
            .wd_i   (wd[g]),
            .re_i   (re[g]),
            .lock_i (lock[g]),
            .de_i   (de[g]),
            .d_i    (d[g]),
            .qe_o   (qe[g]),
            .q_o    (q[g]),
            .ds_o   (ds[g]),
            .qs_o   (qs[g]),
            .err_o  (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       lock;
        logic       de;
        logic [7:0] d;
        logic [7:0] qs;   // read-back before the edge
        logic [7:0] q;    // value after the edge (also ds before it)
        logic       qe;
        logic       err;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < ND; i++) begin
            we[i] = 1'b0; wd[i] = 8'h00; re[i] = 1'b0;
            lock[i] = 1'b0; de[i] = 1'b0; d[i] = 8'h00;
        end
    endtask

    initial begin
        // RW
        vecs[0]  = '{0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h3C, 1'b1, 1'b0};
        vecs[1]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[2]  = '{0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h22, 8'h3C, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[4]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h22, 8'hA5, 1'b0, 1'b0};
        vecs[5]  = '{0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b1};
        vecs[6]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[7]  = '{0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h44, 1'b1, 1'b0};
        vecs[9]  = '{0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 8'h55, 1'b1, 1'b0};
        // W1C
        vecs[10] = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h5A, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'hF0, 8'hFF, 8'hF0, 1'b1, 1'b0};
        vecs[12] = '{1, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF0, 8'hC0, 1'b1, 1'b0};
        // W1S
        vecs[13] = '{2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{2, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h81, 1'b1, 1'b0};
        vecs[15] = '{2, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h10, 8'h81, 8'h12, 1'b1, 1'b0};
        // RO
        vecs[16] = '{3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b1};
        vecs[17] = '{3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h33, 8'h5A, 8'h33, 1'b0, 1'b1};
        vecs[18] = '{3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 8'h33, 1'b0, 1'b0};
        // RC
        vecs[19] = '{4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 8'h5A, 8'h44, 1'b0, 1'b0};
        vecs[20] = '{4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 8'h44, 8'h00, 1'b0, 1'b0};
        vecs[21] = '{4, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[22] = '{4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0};
        vecs[23] = '{4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 8'h00, 1'b0, 1'b0};
        // WO
        vecs[24] = '{5, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b1, 1'b0};
        vecs[25] = '{5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 1'b0};
        // W0C
        vecs[26] = '{6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h5A, 8'hF0, 1'b0, 1'b0};
        vecs[27] = '{6, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF0, 8'h30, 1'b1, 1'b0};

        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            check("rst_q", i, q[i], 8'h5A);
            check("rst_qe", i, {7'd0, qe[i]}, 8'h00);
            check("rst_err", i, {7'd0, err[i]}, 8'h00);
        end
        check("rst_qs_wo", 5, qs[5], 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_q", 0, q[0], 8'h5A);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            idle_all();
            we[vecs[i].dut]   = vecs[i].we;
            wd[vecs[i].dut]   = vecs[i].wd;
            re[vecs[i].dut]   = vecs[i].re;
            lock[vecs[i].dut] = vecs[i].lock;
            de[vecs[i].dut]   = vecs[i].de;
            d[vecs[i].dut]    = vecs[i].d;
            #1;
            check("qs", i, qs[vecs[i].dut], vecs[i].qs);
            check("ds", i, ds[vecs[i].dut], vecs[i].q);
            @(posedge clk);
            #1;
            check("q", i, q[vecs[i].dut], vecs[i].q);
            check("qe", i, {7'd0, qe[vecs[i].dut]}, {7'd0, vecs[i].qe});
            check("err", i, {7'd0, err[vecs[i].dut]}, {7'd0, vecs[i].err});
        end

        // Asynchronous reset between edges, right after a write and a rejected write.
        @(negedge clk);
        idle_all();
        we[0] = 1'b1;
        wd[0] = 8'h99;
        we[3] = 1'b1;
        @(posedge clk);
        #1;
        check("pre_arst_q", 0, q[0], 8'h99);
        check("pre_arst_qe", 0, {7'd0, qe[0]}, 8'h01);
        check("pre_arst_err", 3, {7'd0, err[3]}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", 0, q[0], 8'h5A);
        check("arst_qe", 0, {7'd0, qe[0]}, 8'h00);
        check("arst_err", 3, {7'd0, err[3]}, 8'h00);
        check("arst_q_ro", 3, q[3], 8'h5A);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_hold_q", 0, q[0], 8'h5A);
        check("arst_hold_qe", 0, {7'd0, qe[0]}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
